mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the pipelined core's instruction-fetch port and data (load/store) port.
- Latches the winning request, holds it on the memory interface for MEM_LATENCY cycles, then returns read data with a one-cycle ready pulse.
- Sits between the core datapath and the memory inside top.
- The core stalls F or M while the corresponding ready is low and its request is pending.

Parameters:
- MEM_LATENCY, 2, memory access cycles from mem_en assertion to valid mem_rdata; legal range 1..15.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, held until if_ready.
- if_addr  in  ADDR_W  fetch address (PCF).
- if_rdata  out  DATA_W  fetched instruction, registered.
- if_ready  out  1  one-cycle pulse: fetch complete.
- d_req  in  1  data request, held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address (DataAdr).
- d_wdata  in  DATA_W  store data (WriteData).
- d_be  in  DATA_W/8  store byte enables.
- d_rdata  out  DATA_W  load data, registered.
- d_ready  out  1  one-cycle pulse: data access complete.
- mem_en  out  1  memory access active.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  memory read data, valid in the last BUSY cycle.
- busy  out  1  high in BUSY and DONE.

Behaviour:
- Reset (async, any state), all outputs registered:
  - state = IDLE.
  - mem_en, mem_we, if_ready, d_ready, busy = 0.
  - mem_addr, mem_wdata, mem_be, if_rdata, d_rdata = 0.
  - last_grant = FETCH; cnt = 0.
- States are IDLE, BUSY and DONE.
- IDLE:
  - No request: stay in IDLE, mem_en = 0.
  - Exactly one request: grant it.
  - Both requests: grant the port not equal to last_grant (round-robin). After reset, data wins the first tie.
  - On grant, at the clock edge:
    - Latch address, we, wdata and be into the mem_* registers. Fetch drives we = 0 and be = all ones.
    - Set owner and last_grant to the granted port.
    - Set cnt = MEM_LATENCY-1, mem_en = 1, go to BUSY.
- BUSY:
  - mem_* are stable and requester inputs are ignored; address changes mid-access have no effect.
  - cnt decrements each cycle.
  - When cnt == 0, at the edge:
    - Capture mem_rdata into the owner's rdata. For a store, d_rdata is unchanged.
    - Pulse the owner's ready = 1 and deassert mem_en and mem_we.
    - Go to DONE.
- DONE:
  - Lasts exactly one cycle, with ready high. No arbitration occurs, so a request still held during the ready cycle is not re-granted.
  - Next state is IDLE.
- Latency:
  - Request sampled in IDLE at cycle T.
  - BUSY spans T+1 .. T+MEM_LATENCY.
  - Ready is high in cycle T+MEM_LATENCY+1.
  - IDLE is reached at T+MEM_LATENCY+2.
  - Back-to-back throughput is one access per MEM_LATENCY+2 cycles.
- Request dropped during BUSY: the access still completes and ready still pulses. For a store, the write is performed.
- MEM_LATENCY = 1: BUSY lasts one cycle.
- if_ready and d_ready are never high in the same cycle.
- rdata outputs hold their value until the next completion for the same port.
- Reset during BUSY aborts the access. mem_en falls immediately (async) and no ready pulse is issued.

Test Plan:
- Data only, MEM_LATENCY = 2: load at d_addr = 100, memory returns 25 in the last BUSY cycle.
  -> mem_en high for 2 cycles, d_ready pulses 3 cycles after the request, d_rdata = 25, if_ready stays 0.
- Store: d_we = 1, d_addr = 104, d_wdata = 4096, d_be = 4'b1111.
  -> mem_we = 1 with mem_addr = 104 and mem_wdata = 4096 for 2 cycles, d_ready pulse, d_rdata unchanged.
- Simultaneous if_req (addr 0x0) and d_req (addr 108) right after reset.
  -> data granted first. Fetch is granted in the IDLE following DONE, and if_ready pulses 4 cycles after d_ready.
- Both ports held high continuously for 6 accesses.
  -> grants alternate D, F, D, F, D, F; no port is granted twice in a row.
- Request held high through the ready cycle with a new address (112) presented in DONE.
  -> no duplicate grant in DONE; the next access uses mem_addr = 112.
- Assert reset for 1 cycle mid-BUSY.
  -> mem_en = 0 immediately, no ready pulse, state IDLE. The next tie goes to data.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory
// between the instruction-fetch and load/store ports.
module mem_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } stateT;

  typedef enum logic {
    FETCH,
    DATA
  } portT;

  stateT            state;
  stateT            stateNext;
  portT             owner;
  portT             lastGrant;
  portT             grantPort;
  logic             grantEn;
  logic             finish;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    stateNext = state;
    grantEn   = 1'b0;
    grantPort = FETCH;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (if_req || d_req) begin
          grantEn   = 1'b1;
          stateNext = BUSY;
          // A tie goes to whichever port did not win last time.
          if (if_req && d_req) begin
            grantPort = (lastGrant == FETCH) ? DATA : FETCH;
          end else begin
            grantPort = d_req ? DATA : FETCH;
          end
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          finish    = 1'b1;
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= FETCH;
      lastGrant <= FETCH;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      state    <= stateNext;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      if (grantEn) begin
        owner     <= grantPort;
        lastGrant <= grantPort;
        cnt       <= CNT_LOAD;
        mem_en    <= 1'b1;
        busy      <= 1'b1;
        if (grantPort == DATA) begin
          mem_addr  <= d_addr;
          mem_we    <= d_we;
          mem_wdata <= d_wdata;
          mem_be    <= d_be;
        end else begin
          mem_addr  <= if_addr;
          mem_we    <= 1'b0;
          mem_wdata <= '0;
          mem_be    <= '1;
        end
      end
      if (state == BUSY && !finish) begin
        cnt <= cnt - 1'b1;
      end
      if (finish) begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
        if (owner == DATA) begin
          d_ready <= 1'b1;
          if (!mem_we) begin
            d_rdata <= mem_rdata;
          end
        end else begin
          if_ready <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end
      if (state == DONE) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed and random requests
// compared every cycle against a transaction-timeline model.
module tb_mem_arbiter;

  localparam int LAT = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = DW / 8;
  localparam int L2  = LAT + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_be;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  mem_arbiter #(
    .MEM_LATENCY(LAT),
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_rdata(if_rdata),
    .if_ready(if_ready),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_be(d_be),
    .d_rdata(d_rdata),
    .d_ready(d_ready),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be(mem_be),
    .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memFn(
    input logic [31:0] a
  );
    if (a == 32'd100) return 32'd25;
    return (a * 32'h9E37) ^ 32'h5A5A_1234;
  endfunction

  // Memory returns good data only in the last access cycle.
  int memCyc = 0;
  always @(posedge clk) memCyc <= mem_en ? memCyc + 1 : 0;
  assign mem_rdata = (mem_en && memCyc == LAT - 1) ?
    memFn(mem_addr) : 32'hBAD0_BAD0;

  int nChecks = 0;
  int nFails  = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h",
        tag, got, exp);
    end
  endtask

  int          cyc;
  int          grantT;
  bit          own;
  bit          lastData;
  logic [31:0] lAddr;
  logic [31:0] lWdata;
  logic        lWe;
  logic [3:0]  lBe;
  logic [31:0] eIf;
  logic [31:0] eD;

  task automatic modelReset();
    grantT   = -1000;
    own      = 1'b0;
    lastData = 1'b0;
    lAddr    = '0;
    lWdata   = '0;
    lWe      = 1'b0;
    lBe      = '0;
    eIf      = '0;
    eD       = '0;
  endtask

  task automatic step(
    input bit          ir,
    input logic [31:0] ia,
    input bit          dr,
    input bit          dw,
    input logic [31:0] da,
    input logic [31:0] dwd,
    input logic [3:0]  db
  );
    bit en;
    bit rdy;
    @(negedge clk);
    en  = cyc >= grantT + 1 && cyc <= grantT + LAT;
    rdy = cyc == grantT + LAT + 1;
    if (rdy) begin
      if (own) begin
        if (!lWe) eD = memFn(lAddr);
      end else begin
        eIf = memFn(lAddr);
      end
    end
    chk("mem_en", mem_en, en);
    chk("mem_we", mem_we, en && lWe);
    chk("mem_addr", mem_addr, lAddr);
    chk("mem_wdata", mem_wdata, lWdata);
    chk("mem_be", mem_be, lBe);
    chk("if_ready", if_ready, rdy && !own);
    chk("d_ready", d_ready, rdy && own);
    chk("busy", busy, en || rdy);
    chk("if_rdata", if_rdata, eIf);
    chk("d_rdata", d_rdata, eD);
    chk("both_ready", if_ready && d_ready, 0);
    reset   = 1'b0;
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dw;
    d_addr  = da;
    d_wdata = dwd;
    d_be    = db;
    if (cyc >= grantT + LAT + 2 && (ir || dr)) begin
      own      = (ir && dr) ? !lastData : dr;
      lastData = own;
      grantT   = cyc;
      if (own) begin
        lAddr  = da;
        lWe    = dw;
        lWdata = dwd;
        lBe    = db;
      end else begin
        lAddr  = ia;
        lWe    = 1'b0;
        lWdata = '0;
        lBe    = 4'hF;
      end
    end
    cyc++;
  endtask

  task automatic hold(
    input int          n,
    input bit          ir,
    input logic [31:0] ia,
    input bit          dr,
    input bit          dw,
    input logic [31:0] da,
    input logic [31:0] dwd,
    input logic [3:0]  db
  );
    repeat (n) step(ir, ia, dr, dw, da, dwd, db);
  endtask

  task automatic idle(input int n);
    hold(n, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset lands mid-cycle; outputs must clear without a clock.
  task automatic pulseReset();
    reset = 1'b1;
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_d_ready", d_ready, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    modelReset();
    if_req = 1'b0;
    d_req  = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    d_be    = '0;
    cyc     = 0;
    modelReset();
    repeat (2) @(negedge clk);
    chk("init_mem_en", mem_en, 0);
    chk("init_busy", busy, 0);
    chk("init_mem_be", mem_be, 0);
    chk("init_ready", {if_ready, d_ready}, 0);

    hold(L2, 0, 0, 1, 0, 100, 0, 0);
    idle(2);
    chk("load_rdata", d_rdata, 25);

    hold(L2, 0, 0, 1, 1, 104, 4096, 4'hF);
    idle(2);
    chk("store_keeps_rdata", d_rdata, 25);

    pulseReset();
    hold(L2, 1, 0, 1, 0, 108, 0, 0);
    hold(L2, 1, 0, 0, 0, 0, 0, 0);
    idle(2);

    hold(6 * L2, 1, 32'h200, 1, 0, 32'h300, 0, 0);
    idle(2);

    hold(LAT + 1, 0, 0, 1, 0, 108, 0, 0);
    hold(LAT + 3, 0, 0, 1, 0, 112, 0, 0);
    idle(2);
    chk("next_addr", mem_addr, 112);

    hold(2, 0, 0, 1, 1, 116, 32'hABCD, 4'h3);
    pulseReset();
    hold(L2, 1, 32'h40, 1, 0, 120, 0, 0);
    idle(2);
    chk("post_reset_tie", mem_addr, 120);

    repeat (3000) begin
      if ($urandom_range(0, 299) == 0) begin
        pulseReset();
      end else begin
        step($urandom_range(0, 2) != 0,
             32'($urandom_range(0, 1023)) << 2,
             $urandom_range(0, 2) != 0,
             $urandom_range(0, 1) != 0,
             32'($urandom_range(0, 1023)) << 2,
             $urandom,
             4'($urandom));
      end
    end
    idle(L2);

    $display("End of test - %0d assertions evaluated, %0d failures",
      nChecks, nFails);
    $finish;
  end

endmodule
